rotated_word_serializer: RTL and testbench
==========================================

// Module: rotated_word_serializer
// PURPOSE
//   Downstream stage of the left barrel rotator. Accepts one 2**N-bit rotated
//   word per valid/ready handshake and emits it one bit per accepted beat on a
//   serial valid/ready stream, flagging the final bit. Back-to-back words stream
//   with no idle cycle between them.
// PARAMETERS
//   N          4   log2 of word width; word width W = 2**N (matches rotator N)
//   MSB_FIRST  1   1: bit W-1 is sent first; 0: bit 0 is sent first
// PORTS
//   clk           input   1   rising-edge clock
//   rst_n         input   1   asynchronous active-low reset
//   in            input   W   rotated word from the rotator's out
//   in_valid      input   1   in holds a word to transfer
//   in_ready      output  1   serializer can take a word this cycle
//   serial_out    output  1   current serial bit
//   serial_valid  output  1   serial_out is valid
//   serial_ready  input   1   consumer accepts serial_out this cycle
//   serial_last   output  1   current bit is the final bit of the word
//   busy          output  1   a word is loaded and not fully sent
// BEHAVIOUR
// - Reset (rst_n low, async): state=IDLE, shift reg=0, bit counter=0.
//   serial_out=0, serial_valid=0, serial_last=0, busy=0. in_ready forced to 0.
// - FSM states:
//   - IDLE: in_ready=1, serial_valid=0.
//     - in_valid&in_ready: load shift reg <= in, counter <= W-1, go to SHIFT.
//   - SHIFT: serial_valid=1, busy=1.
//     - serial_out = shreg[W-1] if MSB_FIRST, else shreg[0].
//     - serial_last = (counter==0).
// - Beat = serial_valid & serial_ready. On a beat with counter!=0:
//   - Shift toward the output end: left if MSB_FIRST, else right. Zero fill.
//   - counter <= counter-1.
// - Final beat (counter==0):
//   - in_ready = serial_ready in that cycle. This is a combinational path
//     serial_ready -> in_ready.
//   - If in_valid: load the new word, counter <= W-1, stay in SHIFT. No bubble.
//   - Else: go to IDLE.
// - Stall (serial_valid & !serial_ready): shreg, counter, serial_out and
//   serial_last hold.
// - in_ready=0 in SHIFT except on the final beat. in is ignored unless
//   in_valid & in_ready.
// - Latency: the first bit of a word is valid on the cycle after its handshake.
//   A word occupies exactly W beats.
// - Counter is N bits wide. It never wraps, because it is reloaded to W-1 at
//   each load.
// - Reset mid-word: the word is discarded, outputs return to reset values at
//   once, and no partial serial_last is produced.
// - All outputs other than in_ready are decoded from registered state only.
// TESTING
// - Reset then idle, in_valid=0:
//   -> in_ready=1, serial_valid=0, busy=0 for 20 cycles.
// - N=4, MSB_FIRST=1, in=16'hA5C3, serial_ready=1:
//   -> 16 beats: 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1.
//   -> serial_last high on beat 16 only, then IDLE.
// - Same word, serial_ready toggled 1,0,0,1,...:
//   -> serial_out/serial_last frozen on ready=0 cycles.
//   -> Identical 16-bit sequence, 16 beats total.
// - Back-to-back 16'hFFFF then 16'h0001, in_valid held, serial_ready=1:
//   -> 32 consecutive valid beats, sixteen 1s, fifteen 0s, then a 1.
//   -> serial_last on beats 16 and 32.
// - rst_n pulsed low after beat 5 of 16'hA5C3:
//   -> Outputs zero at once, busy=0.
//   -> Next word 16'h8000 serializes 1 then fifteen 0s.
// - MSB_FIRST=0, in=16'h0003:
//   -> First two bits 1,1, then fourteen 0s, serial_last on beat 16.

Source files
------------

// File: rtl/rotated_word_serializer.sv
// ---------------------------------------------------------------------------
// rotated_word_serializer
//
// Purpose:
//   Downstream stage of the left barrel rotator. Takes one W = 2**N bit word
//   per in_valid/in_ready handshake and streams it out one bit per accepted
//   beat on a serial valid/ready interface. The final bit of each word is
//   flagged with serial_last. A new word can be accepted on the final beat
//   of the current one, so consecutive words stream with no idle cycle.
//
// Parameters:
//   N          log2 of the word width (W = 2**N)
//   MSB_FIRST  1: bit W-1 leaves first, 0: bit 0 leaves first
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in            W-bit rotated word from the rotator
//   in_valid      in holds a word to transfer
//   in_ready      serializer can take a word this cycle (combinational)
//   serial_out    current serial bit
//   serial_valid  serial_out is valid
//   serial_ready  consumer accepts serial_out this cycle
//   serial_last   current bit is the final bit of the word
//   busy          a word is loaded and not fully sent
// ---------------------------------------------------------------------------
module rotated_word_serializer #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [(2**N)-1:0] in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              serial_out,
  output logic              serial_valid,
  input  logic              serial_ready,
  output logic              serial_last,
  output logic              busy
);

  localparam int W = 2**N;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_shreg;
  logic [N-1:0]   r_cnt;

  state_t         w_stateNext;
  logic [W-1:0]   w_shregNext;
  logic [N-1:0]   w_cntNext;
  logic           w_inReadyRaw;
  logic           w_lastBit;
  logic           w_outBit;

  // State register: the shift register and bit counter travel with the FSM
  // state so a reset discards any partially sent word in one step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_shreg <= w_shregNext;
      r_cnt   <= w_cntNext;
    end
  end

  assign w_lastBit = (r_cnt == '0);

  // Next-state logic. A beat on the final bit frees the register, so the
  // upstream handshake is opened in that same cycle; this is what lets
  // back-to-back words stream without a bubble, at the cost of a
  // combinational serial_ready -> in_ready path.
  always_comb begin
    w_stateNext  = r_state;
    w_shregNext  = r_shreg;
    w_cntNext    = r_cnt;
    w_inReadyRaw = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReadyRaw = 1'b1;
        if (in_valid) begin
          w_shregNext = in;
          w_cntNext   = N'(W-1);
          w_stateNext = SHIFT;
        end
      end
      SHIFT: begin
        if (serial_ready) begin
          if (w_lastBit) begin
            w_inReadyRaw = 1'b1;
            if (in_valid) begin
              w_shregNext = in;
              w_cntNext   = N'(W-1);
            end else begin
              w_stateNext = IDLE;
            end
          end else begin
            if (MSB_FIRST) begin
              w_shregNext = {r_shreg[W-2:0], 1'b0};
            end else begin
              w_shregNext = {1'b0, r_shreg[W-1:1]};
            end
            w_cntNext = r_cnt - 1'b1;
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // The residual bit left in the shift register after a word finishes is
  // masked so serial_out reads 0 whenever no word is being sent.
  assign w_outBit     = MSB_FIRST ? r_shreg[W-1] : r_shreg[0];

  assign in_ready     = rst_n & w_inReadyRaw;
  assign serial_valid = (r_state == SHIFT);
  assign busy         = (r_state == SHIFT);
  assign serial_out   = (r_state == SHIFT) & w_outBit;
  assign serial_last  = (r_state == SHIFT) & w_lastBit;

endmodule

// File: tb/tb_rotated_word_serializer.sv
// ---------------------------------------------------------------------------
// tb_rotated_word_serializer
//
// Directed bench for rotated_word_serializer. Instance A is MSB-first,
// instance B is LSB-first; both share clock and reset.
// ---------------------------------------------------------------------------
module tb_rotated_word_serializer;

  logic        clk;
  logic        rst_n;

  logic [15:0] inA;
  logic        inValidA;
  logic        inReadyA;
  logic        serialOutA;
  logic        serialValidA;
  logic        serialReadyA;
  logic        serialLastA;
  logic        busyA;

  logic [15:0] inB;
  logic        inValidB;
  logic        inReadyB;
  logic        serialOutB;
  logic        serialValidB;
  logic        serialReadyB;
  logic        serialLastB;
  logic        busyB;

  int vectors;
  int miscompares;

  rotated_word_serializer #(.N(4), .MSB_FIRST(1'b1)) dutA (
    .clk          (clk),
    .rst_n        (rst_n),
    .in           (inA),
    .in_valid     (inValidA),
    .in_ready     (inReadyA),
    .serial_out   (serialOutA),
    .serial_valid (serialValidA),
    .serial_ready (serialReadyA),
    .serial_last  (serialLastA),
    .busy         (busyA)
  );

  rotated_word_serializer #(.N(4), .MSB_FIRST(1'b0)) dutB (
    .clk          (clk),
    .rst_n        (rst_n),
    .in           (inB),
    .in_valid     (inValidB),
    .in_ready     (inReadyB),
    .serial_out   (serialOutB),
    .serial_valid (serialValidB),
    .serial_ready (serialReadyB),
    .serial_last  (serialLastB),
    .busy         (busyB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted then idle with no input traffic
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({serialOutA, serialValidA, serialLastA, busyA, inReadyA} !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got=%b want=00000",
               {serialOutA, serialValidA, serialLastA, busyA, inReadyA});
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 20; c++) begin
      vectors++;
      if ({inReadyA, serialValidA, busyA} !== 3'b100) begin
        miscompares++;
        $display("[TB] FAIL idle_cycle%0d got=%b want=100", c,
                 {inReadyA, serialValidA, busyA});
      end
      tick();
    end
  endtask

  // Present a word to the selected instance and check it streams out
  // bit by bit. mode 0: serial_ready held high; mode 1: ready pattern
  // 1,0,0,1 repeating so stalls are exercised.
  task automatic serialize(input int sel, input logic [15:0] word, input bit msbFirst,
                           input int mode, input string name);
    int   idx;
    int   cyc;
    logic rdy;
    logic expBit;
    logic v;
    logic o;
    logic l;
    logic b;
    logic ir;
    if (sel == 0) begin
      inA = word; inValidA = 1'b1; serialReadyA = 1'b1;
    end else begin
      inB = word; inValidB = 1'b1; serialReadyB = 1'b1;
    end
    #1;
    ir = (sel == 0) ? inReadyA : inReadyB;
    vectors++;
    if (ir !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_load_ready got=%b want=1", name, ir);
    end
    tick();
    inValidA = 1'b0;
    inValidB = 1'b0;
    inA = 16'h0000;
    inB = 16'h0000;
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 64) begin
      rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      serialReadyA = rdy;
      serialReadyB = rdy;
      #1;
      v = (sel == 0) ? serialValidA : serialValidB;
      o = (sel == 0) ? serialOutA   : serialOutB;
      l = (sel == 0) ? serialLastA  : serialLastB;
      expBit = msbFirst ? word[15-idx] : word[idx];
      vectors++;
      if (v !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL %s_valid_beat%0d got=%b want=1", name, idx, v);
      end else begin
        vectors++;
        if ({o, l} !== {expBit, (idx == 15)}) begin
          miscompares++;
          $display("[TB] FAIL %s_bit%0d ready=%b got out/last=%b%b want=%b%b",
                   name, idx, rdy, o, l, expBit, (idx == 15));
        end
        if (rdy) idx++;
      end
      tick();
      cyc++;
    end
    serialReadyA = 1'b1;
    serialReadyB = 1'b1;
    #1;
    vectors++;
    if (idx != 16) begin
      miscompares++;
      $display("[TB] FAIL %s_beat_count got=%0d want=16", name, idx);
    end
    v = (sel == 0) ? serialValidA : serialValidB;
    b = (sel == 0) ? busyA : busyB;
    vectors++;
    if ({v, b} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL %s_back_to_idle got valid/busy=%b%b want=00", name, v, b);
    end
  endtask

  // FFFF followed immediately by 0001 with in_valid held
  task automatic test_back_to_back();
    int          idx;
    int          cyc;
    logic [31:0] expStream;
    expStream = 32'hFFFF_0001;
    inA = 16'hFFFF;
    inValidA = 1'b1;
    serialReadyA = 1'b1;
    tick();
    inA = 16'h0001;
    idx = 0;
    cyc = 0;
    while (idx < 32 && cyc < 64) begin
      #1;
      if (idx == 15) begin
        vectors++;
        if (inReadyA !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL b2b_final_ready got=%b want=1", inReadyA);
        end
      end else if (idx == 3) begin
        vectors++;
        if (inReadyA !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL b2b_midword_ready got=%b want=0", inReadyA);
        end
      end
      vectors++;
      if (serialValidA !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_gap beat%0d got valid=%b want=1", idx, serialValidA);
      end else begin
        vectors++;
        if ({serialOutA, serialLastA} !== {expStream[31-idx], (idx == 15 || idx == 31)}) begin
          miscompares++;
          $display("[TB] FAIL b2b_bit%0d got out/last=%b%b want=%b%b", idx,
                   serialOutA, serialLastA, expStream[31-idx], (idx == 15 || idx == 31));
        end
        idx++;
      end
      tick();
      cyc++;
      if (idx == 16) inValidA = 1'b0;
    end
    inValidA = 1'b0;
    #1;
    vectors++;
    if (idx != 32) begin
      miscompares++;
      $display("[TB] FAIL b2b_beat_count got=%0d want=32", idx);
    end
    vectors++;
    if ({serialValidA, busyA} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL b2b_idle got valid/busy=%b%b want=00", serialValidA, busyA);
    end
  endtask

  // Reset pulsed after five beats of A5C3, then a fresh word
  task automatic test_reset_midword();
    inA = 16'hA5C3;
    inValidA = 1'b1;
    serialReadyA = 1'b1;
    tick();
    inValidA = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    vectors++;
    if (busyA !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_busy_before_reset got=%b want=1", busyA);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({serialOutA, serialValidA, serialLastA, busyA, inReadyA} !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL mid_reset_outputs got=%b want=00000",
               {serialOutA, serialValidA, serialLastA, busyA, inReadyA});
    end
    tick();
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({inReadyA, serialValidA, busyA} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL mid_after_release got=%b want=100",
               {inReadyA, serialValidA, busyA});
    end
    serialize(0, 16'h8000, 1'b1, 0, "after_reset_8000");
  endtask

  task automatic test_msb_first();
    serialize(0, 16'hA5C3, 1'b1, 0, "msb_a5c3");
  endtask

  task automatic test_stall();
    serialize(0, 16'hA5C3, 1'b1, 1, "stall_a5c3");
  endtask

  task automatic test_lsb_first();
    serialize(1, 16'h0003, 1'b0, 0, "lsb_0003");
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b1;
    inA          = 16'h0000;
    inValidA     = 1'b0;
    serialReadyA = 1'b1;
    inB          = 16'h0000;
    inValidB     = 1'b0;
    serialReadyB = 1'b1;
    #3;
    test_reset();
    test_msb_first();
    test_stall();
    test_back_to_back();
    test_reset_midword();
    test_lsb_first();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
